syndrome_calc: RTL and testbench

SYNDROME_CALC -- requirements
Module: syndrome_calc

---
 rtl/syndrome_calc_pkg.sv | 69 ++++++
 rtl/syndrome_calc_if.sv | 33 +++
 rtl/syndrome_calc_gf_const_mul.sv | 32 +++
 rtl/syndrome_calc.sv | 118 +++++++++++
 tb/tb_syndrome_calc.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/syndrome_calc_pkg.sv
// Shared definitions for the BCH syndrome calculator: code select encodings,
// frame lengths, field widths and primitive polynomials.
package syndrome_calc_pkg;

  localparam int unsigned SYN_W = 10;
  localparam int unsigned CNT_W = 10;

  typedef enum logic [1:0] {
    CODE_BCH63   = 2'b00,
    CODE_BCH255  = 2'b01,
    CODE_BCH1023 = 2'b10,
    CODE_ILLEGAL = 2'b11
  } code_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  typedef logic [SYN_W-1:0] gf_elem_t;

  typedef struct packed {
    gf_elem_t s1;
    gf_elem_t s3;
    gf_elem_t s5;
    gf_elem_t s7;
  } syn_t;

  localparam int unsigned N_BCH63   = 63;
  localparam int unsigned N_BCH255  = 255;
  localparam int unsigned N_BCH1023 = 1023;

  localparam int unsigned M_BCH63   = 6;
  localparam int unsigned M_BCH255  = 8;
  localparam int unsigned M_BCH1023 = 10;

  // Primitive polynomials with the x^m term dropped (the reduction mask)
  localparam gf_elem_t POLY_M6  = 10'h003;
  localparam gf_elem_t POLY_M8  = 10'h01D;
  localparam gf_elem_t POLY_M10 = 10'h009;

  function automatic gf_elem_t prim_poly(input int unsigned m);
    gf_elem_t p;
    case (m)
      M_BCH63:   p = POLY_M6;
      M_BCH255:  p = POLY_M8;
      M_BCH1023: p = POLY_M10;
      default:   p = '0;
    endcase
    return p;
  endfunction

  function automatic gf_elem_t field_mask(input int unsigned m);
    return SYN_W'((32'd1 << m) - 32'd1);
  endfunction

  // Counter value of the final coefficient r(0) for a latched code
  function automatic logic [CNT_W-1:0] last_idx(input code_e c);
    logic [CNT_W-1:0] idx;
    case (c)
      CODE_BCH63:   idx = CNT_W'(N_BCH63 - 1);
      CODE_BCH255:  idx = CNT_W'(N_BCH255 - 1);
      CODE_BCH1023: idx = CNT_W'(N_BCH1023 - 1);
      default:      idx = CNT_W'(N_BCH63 - 1);
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/syndrome_calc_if.sv
// Frame/bit input and syndrome result bundle for syndrome_calc, with a
// sink view for the downstream early-stop (tp1) stage.
interface syndrome_calc_if;
  import syndrome_calc_pkg::*;

  logic       i_start;
  logic [1:0] i_code;
  logic       i_bit;
  logic       i_valid;

  gf_elem_t   o_S1;
  gf_elem_t   o_S3;
  gf_elem_t   o_S5;
  gf_elem_t   o_S7;
  logic       o_tp1_valid;
  logic       o_busy;
  logic [1:0] o_code;

  modport master (
    output i_start, i_code, i_bit, i_valid,
    input  o_S1, o_S3, o_S5, o_S7, o_tp1_valid, o_busy, o_code
  );

  modport slave (
    input  i_start, i_code, i_bit, i_valid,
    output o_S1, o_S3, o_S5, o_S7, o_tp1_valid, o_busy, o_code
  );

  modport tp1_sink (
    input o_S1, o_S3, o_S5, o_S7, o_tp1_valid, o_code
  );

endinterface

// File: rtl/syndrome_calc_gf_const_mul.sv
// Combinational multiply of a GF(2^M) element by the constant alpha^K,
// built as K successive multiply-by-alpha steps reduced by the field poly.
module gf_const_mul
  import syndrome_calc_pkg::*;
#(
  parameter int unsigned M = 6,
  parameter int unsigned K = 1
) (
  input  gf_elem_t i_a,
  output gf_elem_t o_prod_c
);

  localparam gf_elem_t FIELD_MASK = field_mask(M);
  localparam gf_elem_t POLY_LOW   = prim_poly(M);

  gf_elem_t acc;
  logic     msb;

  always_comb begin
    acc = i_a & FIELD_MASK;
    msb = 1'b0;
    for (int unsigned s = 0; s < K; s++) begin
      msb = acc[M-1];
      acc = (acc << 1) & FIELD_MASK;
      if (msb) begin
        acc = acc ^ POLY_LOW;
      end
    end
    o_prod_c = acc;
  end

endmodule

// File: rtl/syndrome_calc.sv
// Serial BCH syndrome calculator: Horner evaluation of S1/S3/S5/S7 over a
// received frame, one hard-decision bit per accepted cycle, MSB coefficient first.
module syndrome_calc
  import syndrome_calc_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  syndrome_calc_if.slave  bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  code_e              code_q, code_d;
  syn_t               syn_q, syn_d;
  logic               tp1_q, tp1_d;
  logic               busy_q, busy_d;

  code_e              in_code;
  logic               start_ok;
  syn_t               mul;

  gf_elem_t m6_s1, m6_s3;
  gf_elem_t m8_s1, m8_s3;
  gf_elem_t m10_s1, m10_s3, m10_s5, m10_s7;

  assign in_code  = code_e'(bus.i_code);
  assign start_ok = bus.i_start && (in_code != CODE_ILLEGAL);

  // Constant multipliers per field; t=2 fields need only S1 and S3
  gf_const_mul #(.M(M_BCH63),   .K(1)) u_m6_s1  (.i_a(syn_q.s1), .o_prod_c(m6_s1));
  gf_const_mul #(.M(M_BCH63),   .K(3)) u_m6_s3  (.i_a(syn_q.s3), .o_prod_c(m6_s3));
  gf_const_mul #(.M(M_BCH255),  .K(1)) u_m8_s1  (.i_a(syn_q.s1), .o_prod_c(m8_s1));
  gf_const_mul #(.M(M_BCH255),  .K(3)) u_m8_s3  (.i_a(syn_q.s3), .o_prod_c(m8_s3));
  gf_const_mul #(.M(M_BCH1023), .K(1)) u_m10_s1 (.i_a(syn_q.s1), .o_prod_c(m10_s1));
  gf_const_mul #(.M(M_BCH1023), .K(3)) u_m10_s3 (.i_a(syn_q.s3), .o_prod_c(m10_s3));
  gf_const_mul #(.M(M_BCH1023), .K(5)) u_m10_s5 (.i_a(syn_q.s5), .o_prod_c(m10_s5));
  gf_const_mul #(.M(M_BCH1023), .K(7)) u_m10_s7 (.i_a(syn_q.s7), .o_prod_c(m10_s7));

  always_comb begin
    mul = '0;
    case (code_q)
      CODE_BCH63: begin
        mul.s1 = m6_s1;
        mul.s3 = m6_s3;
      end
      CODE_BCH255: begin
        mul.s1 = m8_s1;
        mul.s3 = m8_s3;
      end
      CODE_BCH1023: begin
        mul.s1 = m10_s1;
        mul.s3 = m10_s3;
        mul.s5 = m10_s5;
        mul.s7 = m10_s7;
      end
      default: mul = '0;
    endcase
  end

  // Next state: a legal start always wins, even over the final bit of a frame
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    syn_d   = syn_q;
    tp1_d   = 1'b0;

    if (start_ok) begin
      state_d = ST_ACCUM;
      cnt_d   = '0;
      code_d  = in_code;
      syn_d   = '0;
    end else if ((state_q == ST_ACCUM) && bus.i_valid) begin
      syn_d.s1 = mul.s1 ^ SYN_W'(bus.i_bit);
      syn_d.s3 = mul.s3 ^ SYN_W'(bus.i_bit);
      if (code_q == CODE_BCH1023) begin
        syn_d.s5 = mul.s5 ^ SYN_W'(bus.i_bit);
        syn_d.s7 = mul.s7 ^ SYN_W'(bus.i_bit);
      end
      if (cnt_q == last_idx(code_q)) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        tp1_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    busy_d = (state_d == ST_ACCUM);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      code_q  <= CODE_BCH63;
      syn_q   <= '0;
      tp1_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      syn_q   <= syn_d;
      tp1_q   <= tp1_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_S1        = syn_q.s1;
  assign bus.o_S3        = syn_q.s3;
  assign bus.o_S5        = syn_q.s5;
  assign bus.o_S7        = syn_q.s7;
  assign bus.o_tp1_valid = tp1_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_code      = code_q;

endmodule

// File: tb/tb_syndrome_calc.sv
// Self-checking bench for syndrome_calc: table vectors, hand-written abort and
// reset sequences, and random frames against a power-sum syndrome model.
module tb_syndrome_calc;

  typedef struct {
    int         code;
    int         pat;   // 0 zeros, 1 last two ones, 2 first one, 3 last one
    logic [9:0] s1, s3, s5, s7;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   pulses;
  int   busy_bad;
  bit   frame_bits [0:1022];
  int   pw6  [0:62];
  int   pw8  [0:254];
  int   pw10 [0:1022];
  vec_t vt [6];
  int   e1, e3, e5, e7;

  syndrome_calc_if bus();

  syndrome_calc dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.o_tp1_valid === 1'b1) pulses++;

  function automatic int code_n(input int c);
    return (c == 0) ? 63 : (c == 1) ? 255 : 1023;
  endfunction

  // Multiply by alpha using the full primitive polynomial
  function automatic int mul_alpha(input int v, input int m);
    int full;
    full = (m == 6) ? 'h43 : (m == 8) ? 'h11D : 'h409;
    v = v << 1;
    if ((v >> m) != 0) v = v ^ full;
    return v;
  endfunction

  function automatic int alpha_pow(input int c, input int e);
    if (c == 0) return pw6[e % 63];
    if (c == 1) return pw8[e % 255];
    return pw10[e % 1023];
  endfunction

  // S_j = sum of alpha^(j*i) over set coefficients r(i); bit k carries r(n-1-k)
  function automatic int model_syn(input int c, input int j);
    int n, s;
    n = code_n(c);
    s = 0;
    if (c != 2 && j >= 5) return 0;
    for (int k = 0; k < n; k++)
      if (frame_bits[k]) s = s ^ alpha_pow(c, (j * (n - 1 - k)) % n);
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill(input int pat, input int n);
    for (int k = 0; k < 1023; k++) begin
      case (pat)
        0:       frame_bits[k] = 1'b0;
        1:       frame_bits[k] = (k >= n - 2);
        2:       frame_bits[k] = (k == 0);
        3:       frame_bits[k] = (k == n - 1);
        default: frame_bits[k] = (k < n) ? bit'($urandom_range(0, 1)) : 1'b0;
      endcase
    end
  endtask

  task automatic start_frame(input int c);
    bus.i_start = 1'b1;
    bus.i_code  = 2'(c);
    bus.i_valid = 1'b0;
    step();
    bus.i_start = 1'b0;
  endtask

  // Send bits [from,to) with random idle gaps; busy must be high before each accept
  task automatic send_bits(input int from, input int to, input int gap_max);
    for (int k = from; k < to; k++) begin
      repeat ($urandom_range(0, gap_max)) begin
        bus.i_valid = 1'b0;
        bus.i_bit   = 1'($urandom_range(0, 1));
        if (bus.o_busy !== 1'b1) busy_bad++;
        step();
      end
      if (bus.o_busy !== 1'b1) busy_bad++;
      bus.i_valid = 1'b1;
      bus.i_bit   = frame_bits[k];
      step();
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic model_all(input int c);
    e1 = model_syn(c, 1);
    e3 = model_syn(c, 3);
    e5 = model_syn(c, 5);
    e7 = model_syn(c, 7);
  endtask

  // Called right after the final bit's edge: pulse now, then gone, values held
  task automatic check_end(input string name, input int c,
                           input int x1, input int x3, input int x5, input int x7);
    chk({name, ".tp1"},  32'(bus.o_tp1_valid), 32'd1);
    chk({name, ".busy"}, 32'(bus.o_busy), 32'd0);
    chk({name, ".code"}, 32'(bus.o_code), 32'(c));
    chk({name, ".S1"},   32'(bus.o_S1), 32'(x1));
    chk({name, ".S3"},   32'(bus.o_S3), 32'(x3));
    chk({name, ".S5"},   32'(bus.o_S5), 32'(x5));
    chk({name, ".S7"},   32'(bus.o_S7), 32'(x7));
    step();
    chk({name, ".tp1_off"}, 32'(bus.o_tp1_valid), 32'd0);
    chk({name, ".S1_hold"}, 32'(bus.o_S1), 32'(x1));
  endtask

  initial begin
    int p0;
    n_vec = 0; n_err = 0; pulses = 0; busy_bad = 0;
    pw6[0] = 1; pw8[0] = 1; pw10[0] = 1;
    for (int e = 1; e < 63;   e++) pw6[e]  = mul_alpha(pw6[e-1], 6);
    for (int e = 1; e < 255;  e++) pw8[e]  = mul_alpha(pw8[e-1], 8);
    for (int e = 1; e < 1023; e++) pw10[e] = mul_alpha(pw10[e-1], 10);

    vt[0] = '{2, 0, 10'h000, 10'h000, 10'h000, 10'h000};
    vt[1] = '{0, 1, 10'h003, 10'h009, 10'h000, 10'h000};
    vt[2] = '{0, 2, 10'h021, 10'h039, 10'h000, 10'h000};
    vt[3] = '{1, 3, 10'h001, 10'h001, 10'h000, 10'h000};
    vt[4] = '{2, 3, 10'h001, 10'h001, 10'h001, 10'h001};
    vt[5] = '{2, 2, 10'h204, 10'h081, 10'h122, 10'h24C};

    rst_n = 1'b0;
    bus.i_start = 1'b0; bus.i_code = 2'b00; bus.i_bit = 1'b0; bus.i_valid = 1'b0;
    #12;
    chk("rst.S1",   32'(bus.o_S1), 32'd0);
    chk("rst.S7",   32'(bus.o_S7), 32'd0);
    chk("rst.tp1",  32'(bus.o_tp1_valid), 32'd0);
    chk("rst.busy", 32'(bus.o_busy), 32'd0);
    chk("rst.code", 32'(bus.o_code), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // Illegal code select is ignored in IDLE
    bus.i_start = 1'b1; bus.i_code = 2'b11;
    step();
    bus.i_start = 1'b0;
    chk("illegal.busy", 32'(bus.o_busy), 32'd0);
    chk("illegal.code", 32'(bus.o_code), 32'd0);

    for (int i = 0; i < 6; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      fill(vt[i].pat, code_n(vt[i].code));
      start_frame(vt[i].code);
      chk({nm, ".busy_start"}, 32'(bus.o_busy), 32'd1);
      p0 = pulses;
      busy_bad = 0;
      send_bits(0, code_n(vt[i].code), 0);
      check_end(nm, vt[i].code, int'(vt[i].s1), int'(vt[i].s3), int'(vt[i].s5), int'(vt[i].s7));
      chk({nm, ".pulses"}, 32'(pulses - p0), 32'd1);
      chk({nm, ".busy_run"}, 32'(busy_bad), 32'd0);
    end

    // 255-bit frame with random gaps
    fill(4, 255);
    model_all(1);
    busy_bad = 0;
    start_frame(1);
    p0 = pulses;
    send_bits(0, 255, 5);
    check_end("gaps", 1, e1, e3, e5, e7);
    chk("gaps.pulses", 32'(pulses - p0), 32'd1);
    chk("gaps.busy_run", 32'(busy_bad), 32'd0);

    // Bits offered in IDLE do not disturb held syndromes
    bus.i_valid = 1'b1;
    repeat (5) begin
      bus.i_bit = 1'b1;
      step();
    end
    bus.i_valid = 1'b0;
    chk("idle_valid.S1",   32'(bus.o_S1), 32'(e1));
    chk("idle_valid.S3",   32'(bus.o_S3), 32'(e3));
    chk("idle_valid.busy", 32'(bus.o_busy), 32'd0);

    // Abort a 1023 frame at bit 500 by restarting with a 63 frame
    fill(4, 1023);
    start_frame(2);
    p0 = pulses;
    send_bits(0, 500, 1);
    bus.i_start = 1'b1; bus.i_code = 2'b00; bus.i_valid = 1'b1; bus.i_bit = 1'b1;
    step();
    bus.i_start = 1'b0; bus.i_valid = 1'b0;
    chk("abort.S1_clr", 32'(bus.o_S1), 32'd0);
    chk("abort.busy",   32'(bus.o_busy), 32'd1);
    chk("abort.code",   32'(bus.o_code), 32'd0);
    fill(4, 63);
    model_all(0);
    send_bits(0, 63, 2);
    check_end("abort", 0, e1, e3, e5, e7);
    chk("abort.pulses", 32'(pulses - p0), 32'd1);

    // Start coincident with the final bit wins over the frame end
    fill(4, 63);
    start_frame(0);
    send_bits(0, 62, 0);
    p0 = pulses;
    bus.i_valid = 1'b1; bus.i_bit = frame_bits[62];
    bus.i_start = 1'b1; bus.i_code = 2'b01;
    step();
    bus.i_start = 1'b0; bus.i_valid = 1'b0;
    chk("coinc.tp1",  32'(bus.o_tp1_valid), 32'd0);
    chk("coinc.busy", 32'(bus.o_busy), 32'd1);
    chk("coinc.code", 32'(bus.o_code), 32'd1);
    chk("coinc.S1",   32'(bus.o_S1), 32'd0);
    fill(4, 255);
    model_all(1);
    send_bits(0, 255, 0);
    check_end("coinc", 1, e1, e3, e5, e7);
    chk("coinc.pulses", 32'(pulses - p0), 32'd1);

    // Asynchronous reset in the middle of a 1023 frame
    fill(4, 1023);
    start_frame(2);
    send_bits(0, 300, 0);
    p0 = pulses;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst.S1",   32'(bus.o_S1), 32'd0);
    chk("mrst.S3",   32'(bus.o_S3), 32'd0);
    chk("mrst.S5",   32'(bus.o_S5), 32'd0);
    chk("mrst.S7",   32'(bus.o_S7), 32'd0);
    chk("mrst.busy", 32'(bus.o_busy), 32'd0);
    chk("mrst.code", 32'(bus.o_code), 32'd0);
    chk("mrst.tp1",  32'(bus.o_tp1_valid), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    bus.i_valid = 1'b1;
    repeat (20) begin
      bus.i_bit = 1'($urandom_range(0, 1));
      step();
    end
    bus.i_valid = 1'b0;
    chk("mrst.no_pulse", 32'(pulses - p0), 32'd0);
    chk("mrst.idle",     32'(bus.o_busy), 32'd0);
    bus.i_start = 1'b1; bus.i_code = 2'b11;
    step();
    bus.i_start = 1'b0;
    chk("mrst.illegal_busy", 32'(bus.o_busy), 32'd0);

    // Random frames for every legal code
    for (int r = 0; r < 6; r++) begin
      int c;
      c = r % 3;
      fill(4, code_n(c));
      model_all(c);
      start_frame(c);
      send_bits(0, code_n(c), (c == 2) ? 1 : 3);
      check_end($sformatf("rand%0d", r), c, e1, e3, e5, e7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
